// File: rtl/blood_abnormality_detector_if.sv
// Sample/verdict bus between acquisition front end and the abnormality detector.
interface blood_abnormality_detector_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               sampleValid;
  logic [3:0]         bloodPH;
  logic [2:0]         bloodType;
  logic               alarmClear;
  logic               bloodAbnormality;
  logic               resultValid;
  logic               invalidType;
  logic               alarmSticky;
  logic [COUNT_W-1:0] abnormalCount;

  modport master (
    output sampleValid, bloodPH, bloodType, alarmClear,
    input  bloodAbnormality, resultValid, invalidType, alarmSticky, abnormalCount
  );

  modport slave (
    input  sampleValid, bloodPH, bloodType, alarmClear,
    output bloodAbnormality, resultValid, invalidType, alarmSticky, abnormalCount
  );
endinterface

// File: rtl/blood_abnormality_detector.sv
// Per-sample pH window check with registered verdict, sticky alarm and saturating count.
// Optional BLOOD_PERSIST_FILTER_EN: verdict needs PERSIST_N consecutive raw-abnormal samples.
module blood_abnormality_detector #(
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned PERSIST_N = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  blood_abnormality_detector_if.slave   bus
);
  localparam int unsigned PH_W  = 4;
  localparam int unsigned RUN_W = 4;

  if (PERSIST_N < 1 || PERSIST_N > 15) begin : g_bad_persist
    $error("PERSIST_N must be in 1..15");
  end

  logic [PH_W-1:0]    low_c, high_c;
  logic               reserved_c, raw_abn_c, verdict_c;

  logic               abn_q, abn_d;
  logic               rv_q, rv_d;
  logic               inv_q, inv_d;
  logic               alarm_q, alarm_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Inclusive normal pH window per blood type; 110/111 are reserved.
  always_comb begin
    low_c      = '0;
    high_c     = '0;
    reserved_c = 1'b0;
    case (bus.bloodType)
      3'd0:    begin low_c = 4'd6; high_c = 4'd9;  end
      3'd1:    begin low_c = 4'd7; high_c = 4'd10; end
      3'd2:    begin low_c = 4'd8; high_c = 4'd11; end
      3'd3:    begin low_c = 4'd7; high_c = 4'd9;  end
      3'd4:    begin low_c = 4'd6; high_c = 4'd8;  end
      3'd5:    begin low_c = 4'd5; high_c = 4'd8;  end
      default: reserved_c = 1'b1;
    endcase
    raw_abn_c = reserved_c | (bus.bloodPH < low_c) | (bus.bloodPH > high_c);
  end

`ifdef BLOOD_PERSIST_FILTER_EN
  logic [RUN_W-1:0] run_q, run_d, run_next_c;

  // Run length includes the current sample; reserved types skip the filter.
  always_comb begin
    run_next_c = '0;
    if (raw_abn_c) run_next_c = (run_q == '1) ? run_q : run_q + RUN_W'(1);
    run_d      = bus.sampleValid ? run_next_c : run_q;
    verdict_c  = reserved_c | (raw_abn_c & (run_next_c >= RUN_W'(PERSIST_N)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= '0;
    else        run_q <= run_d;
  end
`else
  assign verdict_c = raw_abn_c;
`endif

  // Verdict/alarm/count update; an abnormal verdict wins over alarmClear.
  always_comb begin
    abn_d   = abn_q;
    inv_d   = inv_q;
    rv_d    = bus.sampleValid;
    alarm_d = alarm_q;
    count_d = count_q;
    if (bus.alarmClear) alarm_d = 1'b0;
    if (bus.sampleValid) begin
      abn_d = verdict_c;
      inv_d = reserved_c;
      if (verdict_c) begin
        alarm_d = 1'b1;
        if (count_q != '1) count_d = count_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abn_q   <= 1'b0;
      rv_q    <= 1'b0;
      inv_q   <= 1'b0;
      alarm_q <= 1'b0;
      count_q <= '0;
    end else begin
      abn_q   <= abn_d;
      rv_q    <= rv_d;
      inv_q   <= inv_d;
      alarm_q <= alarm_d;
      count_q <= count_d;
    end
  end

  assign bus.bloodAbnormality = abn_q;
  assign bus.resultValid      = rv_q;
  assign bus.invalidType      = inv_q;
  assign bus.alarmSticky      = alarm_q;
  assign bus.abnormalCount    = count_q;
endmodule

// File: tb/tb_blood_abnormality_detector.sv
// Self-checking bench: vector table, corner sequences and random stimulus vs a reference model.
module tb_blood_abnormality_detector;
  localparam int unsigned PN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blood_abnormality_detector_if #(.COUNT_W(8)) bus8 ();
  blood_abnormality_detector_if #(.COUNT_W(2)) bus2 ();

  blood_abnormality_detector #(.COUNT_W(8), .PERSIST_N(PN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  blood_abnormality_detector #(.COUNT_W(2), .PERSIST_N(PN)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  typedef struct {
    logic       v;
    logic [3:0] ph;
    logic [2:0] ty;
    logic       clr;
    logic       exp_raw;
    logic       exp_inv;
  } vec_t;

  vec_t tbl[17];

  int n_vec = 0;
  int n_bad = 0;
  int m_abn, m_inv, m_rv, m_alarm, m_cnt8, m_cnt2, m_run;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_abn"},    int'(bus8.bloodAbnormality), m_abn);
    check({tag, "_rv"},     int'(bus8.resultValid),      m_rv);
    check({tag, "_inv"},    int'(bus8.invalidType),      m_inv);
    check({tag, "_alarm"},  int'(bus8.alarmSticky),      m_alarm);
    check({tag, "_cnt8"},   int'(bus8.abnormalCount),    m_cnt8);
    check({tag, "_cnt2"},   int'(bus2.abnormalCount),    m_cnt2);
    check({tag, "_abn_w2"}, int'(bus2.bloodAbnormality), m_abn);
  endtask

  function automatic int win_raw(input int ph, input int ty);
    int lo[6];
    int hi[6];
    lo = '{6, 7, 8, 7, 6, 5};
    hi = '{9, 10, 11, 9, 8, 8};
    if (ty >= 6) return 1;
    return (ph < lo[ty] || ph > hi[ty]) ? 1 : 0;
  endfunction

  task automatic model_zero();
    m_abn = 0; m_inv = 0; m_rv = 0; m_alarm = 0; m_cnt8 = 0; m_cnt2 = 0; m_run = 0;
  endtask

  task automatic model_step(input logic v, input int raw, input int resv, input logic clr);
    int verdict;
    m_rv = int'(v);
    if (clr) m_alarm = 0;
    if (v) begin
      m_run = raw ? ((m_run < 15) ? m_run + 1 : 15) : 0;
`ifdef BLOOD_PERSIST_FILTER_EN
      verdict = (resv != 0 || (raw != 0 && m_run >= int'(PN))) ? 1 : 0;
`else
      verdict = raw;
`endif
      m_abn = verdict;
      m_inv = resv;
      if (verdict != 0) begin
        m_alarm = 1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic drive(input logic v, input int ph, input int ty, input logic clr);
    bus8.sampleValid = v;  bus8.bloodPH = 4'(ph); bus8.bloodType = 3'(ty); bus8.alarmClear = clr;
    bus2.sampleValid = v;  bus2.bloodPH = 4'(ph); bus2.bloodType = 3'(ty); bus2.alarmClear = clr;
  endtask

  task automatic apply(input string tag, input logic v, input int ph, input int ty,
                       input logic clr, input int raw, input int resv);
    @(negedge clk);
    drive(v, ph, ty, clr);
    @(posedge clk);
    model_step(v, raw, resv, clr);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    model_zero();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    int fexp[6];
    int fph[6];
    int ph, ty;
    logic v, clr;

    tbl[0]  = '{1'b1, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 4'd7,  3'd1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd8,  3'd2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd6,  3'd3, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'd7,  3'd3, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'd9,  3'd3, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'd10, 3'd3, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'd8,  3'd6, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'd0,  3'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'd15, 3'd7, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'd7,  3'd0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'd5,  3'd5, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'd4,  3'd5, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 4'd11, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'd12, 3'd2, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 4'd8,  3'd4, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'd9,  3'd4, 1'b0, 1'b1, 1'b0};

    drive(1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    model_zero();
    #1;
    check_all("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++)
      apply("tbl", tbl[i].v, int'(tbl[i].ph), int'(tbl[i].ty), tbl[i].clr,
            int'(tbl[i].exp_raw), int'(tbl[i].exp_inv));

`ifdef BLOOD_PERSIST_FILTER_EN
    do_reset();
    fph  = '{0, 0, 7, 0, 0, 0};
    fexp = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      apply("filt", 1'b1, fph[i], 0, 1'b0, win_raw(fph[i], 0), 0);
      check("filt_seq", int'(bus8.bloodAbnormality), fexp[i]);
    end
    check("filt_cnt", int'(bus8.abnormalCount), 1);
`endif

    // Narrow counter saturates at 3 after five abnormal samples.
    do_reset();
    for (int i = 0; i < 5; i++) apply("sat2", 1'b1, 0, 7, 1'b0, 1, 1);
    check("w2_sat", int'(bus2.abnormalCount), 3);

    // Asynchronous reset mid-burst, with a sample in flight.
    @(negedge clk);
    drive(1'b1, 0, 7, 1'b0);
    #2 rst_n = 1'b0;
    model_zero();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    apply("post_rst", 1'b0, 0, 0, 1'b0, 0, 0);

    // Wide counter saturates at 255.
    for (int i = 0; i < 258; i++) apply("sat8", 1'b1, 3, 6, 1'b0, 1, 1);
    check("w8_sat", int'(bus8.abnormalCount), 255);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 9) == 0);
      ph  = int'($urandom_range(0, 15));
      ty  = int'($urandom_range(0, 7));
      apply("rand", v, ph, ty, clr, win_raw(ph, ty), (ty >= 6) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/blood_abnormality_detector.md
Name: blood_abnormality_detector

Overview:
- Clocked checker that classifies one blood sample per strobe as normal or abnormal.
- The decision is based on a 4-bit pH code tested against a per-blood-type normal window.
- Sits in the health-care monitoring datapath between the sample acquisition front end and the alarm/reporting logic.
- Provides a registered verdict, a sticky alarm and a saturating abnormal-sample counter.

Parameters:
- COUNT_W, 8: width of abnormalCount.
- PERSIST_N, 3: consecutive abnormal samples required before the verdict asserts. Used only with BLOOD_PERSIST_FILTER_EN; legal range 1..15.

Ports:
- clk  input  1  single system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sampleValid  input  1  qualifies bloodPH/bloodType for this cycle.
- bloodPH  input  4  pH code, unsigned 0..15.
- bloodType  input  3  blood type code.
- alarmClear  input  1  synchronous clear of alarmSticky.
- bloodAbnormality  output  1  registered verdict for the last accepted sample (1 = abnormal).
- resultValid  output  1  one-cycle pulse: verdict outputs updated.
- invalidType  output  1  registered: last accepted sample had a reserved type.
- alarmSticky  output  1  set by any abnormal verdict, held until alarmClear.
- abnormalCount  output  COUNT_W  saturating count of abnormal verdicts.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous): all outputs and internal state go to 0 immediately, and stay 0 until the first accepted sample after rst_n rises.
- A sample is accepted on a rising clk edge with sampleValid=1.
- Latency is 1 cycle. Verdict, invalidType, alarmSticky and abnormalCount update on the accepting edge. resultValid is high for exactly the following cycle.
- With sampleValid=0: bloodAbnormality and invalidType hold their values; resultValid=0; counter and alarm are unchanged (alarmClear still acts).
- Back-to-back samples (sampleValid held high) are accepted every cycle, and resultValid stays high.
- Normal pH window, inclusive, per bloodType:
  - 000: 6..9
  - 001: 7..10
  - 010: 8..11
  - 011: 7..9
  - 100: 6..8
  - 101: 5..8
  - 110, 111: reserved. invalidType=1 and the raw verdict is abnormal.
- Raw abnormal = pH < low, or pH > high, or reserved type. Boundary values low and high are normal.
- abnormalCount increments by 1 per accepted abnormal verdict and saturates at all-ones (no wrap).
- alarmSticky is set by an abnormal verdict and cleared by alarmClear. If both occur in the same cycle, set wins.
- alarmClear does not affect abnormalCount or bloodAbnormality.
- Reset asserted mid-stream discards the in-flight sample. No resultValid is issued for it.
- Pure combinational window lookup plus the registers described; no other state.

Optional Feature:
- Macro: BLOOD_PERSIST_FILTER_EN.
- Defined:
  - A 4-bit consecutive-abnormal run counter (saturating at 15, reset 0) tracks raw abnormal accepted samples; a raw normal sample clears it to 0.
  - bloodAbnormality (and hence count/alarm updates) asserts only when the run length including the current sample reaches ≥ PERSIST_N.
  - Reserved types bypass the filter and assert immediately.
  - Non-accepted cycles do not affect the run counter.
- Not defined: the verdict equals the raw abnormal decision and there is no run counter.

Test Plan:
- Reset, then pH=0, type=000, sampleValid pulse → next cycle resultValid=1, bloodAbnormality=1, abnormalCount=1, alarmSticky=1.
- pH=7, type=001 → bloodAbnormality=0, invalidType=0; then pH=8, type=010 → bloodAbnormality=0; abnormalCount unchanged.
- Boundary sweep on type=011 with pH=6,7,9,10 → verdicts 1,0,0,1 respectively.
- type=110, pH=8 → invalidType=1, bloodAbnormality=1. Assert alarmClear in the same cycle as a new abnormal sample → alarmSticky stays 1; alarmClear alone → 0.
- With COUNT_W=2, apply 5 abnormal samples → abnormalCount saturates at 3. Assert rst_n low mid-burst → all outputs 0 asynchronously.
- With BLOOD_PERSIST_FILTER_EN and PERSIST_N=3: samples type=000 pH=0,0,7,0,0,0 → verdicts 0,0,0,0,0,1 and abnormalCount=1.
